// File: rtl/acc_pkg.sv
`default_nettype none
// acc_pkg: shared widths, frame constants and feeder state encoding for acc16 and its feeder.
// Rev 1.0
package acc_pkg;

    localparam int N_TERMS     = 16;
    localparam int SLOT_CYCLES = 3;
    localparam int X_W         = 8;
    localparam int W_W         = 12;
    localparam int B_W         = 8;
    localparam int DIN_W       = X_W + W_W;
    localparam int IDX_W       = $clog2(N_TERMS);
    localparam int CNT_W       = $clog2(N_TERMS + 1);
    localparam int SC_W        = $clog2(SLOT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/acc16_feeder_if.sv
`default_nettype none
// acc16_feeder_if: operand fetch handshake between the activation/weight store and the feeder.
// Rev 1.0
interface acc16_feeder_if;
    import acc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   x_in;
    logic [W_W-1:0]   w_in;

    modport master (output in_valid, output x_in, output w_in, input in_ready);
    modport slave  (input in_valid, input x_in, input w_in, output in_ready);

endinterface
`default_nettype wire

// File: rtl/acc16_feeder_mul.sv
`default_nettype none
// feeder_mul: combinational X_W x W_W full-width multiplier, signed when FEEDER_SIGNED_EN is defined.
// Rev 1.0
module feeder_mul
    import acc_pkg::*;
(
    input  logic [X_W-1:0]   x_i,
    input  logic [W_W-1:0]   w_i,
    output logic [DIN_W-1:0] p_o
);

`ifdef FEEDER_SIGNED_EN
    assign p_o = $signed({{W_W{x_i[X_W-1]}}, x_i}) * $signed({{X_W{w_i[W_W-1]}}, w_i});
`else
    assign p_o = {{W_W{1'b0}}, x_i} * {{X_W{1'b0}}, w_i};
`endif

endmodule
`default_nettype wire

// File: rtl/acc16_feeder.sv
`default_nettype none
// acc16_feeder: fetches N_TERMS operand pairs, drives products to acc16 on a fixed slot cadence.
// Rev 1.0 -- FEEDER_SIGNED_EN selects two's complement operands and products.
module acc16_feeder
    import acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [B_W-1:0]    bias_in,
    acc16_feeder_if.slave     op,
    output logic [DIN_W-1:0]  din,
    output logic [B_W-1:0]    b,
    output logic              acc_clr,
    output logic              slot_vld,
    output logic [IDX_W-1:0]  idx,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    feeder_state_t     state_q, state_d;
    logic [DIN_W-1:0]  din_q, din_d;
    logic [B_W-1:0]    b_q, b_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SC_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [CNT_W-1:0]  fetched_q, fetched_d;
    logic              slot_vld_q, slot_vld_d;
    logic              underrun_q, underrun_d;

    logic [DIN_W-1:0]  prod_w;
    logic              fetch_w;
    logic              more_w;

    feeder_mul u_mul (
        .x_i (op.x_in),
        .w_i (op.w_in),
        .p_o (prod_w)
    );

    assign fetch_w     = (slot_cnt_q == SC_W'(SLOT_CYCLES - 1));
    assign more_w      = (fetched_q < CNT_W'(N_TERMS));
    assign op.in_ready = (state_q == RUN) && fetch_w && more_w;

    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        b_d        = b_q;
        idx_d      = idx_q;
        slot_cnt_d = slot_cnt_q;
        fetched_d  = fetched_q;
        slot_vld_d = slot_vld_q;
        underrun_d = underrun_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d        = bias_in;
                    fetched_d  = '0;
                    slot_cnt_d = SC_W'(SLOT_CYCLES - 1);
                    underrun_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (fetch_w && more_w) begin
                    // A missing operand still consumes its slot so pacing never slips.
                    din_d      = op.in_valid ? prod_w : '0;
                    underrun_d = underrun_q | ~op.in_valid;
                    idx_d      = fetched_q[IDX_W-1:0];
                    fetched_d  = fetched_q + CNT_W'(1);
                    slot_cnt_d = '0;
                    slot_vld_d = 1'b1;
                end else if (fetch_w) begin
                    din_d      = '0;
                    slot_vld_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    slot_cnt_d = slot_cnt_q + SC_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            din_q      <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            slot_cnt_q <= '0;
            fetched_q  <= '0;
            slot_vld_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
            fetched_q  <= fetched_d;
            slot_vld_q <= slot_vld_d;
            underrun_q <= underrun_d;
        end
    end

    assign din      = din_q;
    assign b        = b_q;
    assign idx      = idx_q;
    assign slot_vld = slot_vld_q;
    assign underrun = underrun_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign acc_clr  = (state_q != RUN);

endmodule
`default_nettype wire

// File: tb/tb_acc16_feeder.sv
`default_nettype none
// tb_acc16_feeder: directed frames with a product scoreboard and per-cycle timing checks.
// Rev 1.0
module tb_acc16_feeder;
    import acc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [B_W-1:0]    bias_in;
    logic [DIN_W-1:0]  din;
    logic [B_W-1:0]    b;
    logic              acc_clr, slot_vld, busy, done, underrun;
    logic [IDX_W-1:0]  idx;

    int total = 0;
    int bad   = 0;
    logic [DIN_W-1:0] sb_q[$];
    logic [DIN_W-1:0] cur_exp;

    acc16_feeder_if op_if ();

    acc16_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bias_in  (bias_in),
        .op       (op_if.slave),
        .din      (din),
        .b        (b),
        .acc_clr  (acc_clr),
        .slot_vld (slot_vld),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DIN_W-1:0] exp_prod(input logic [X_W-1:0] x, input logic [W_W-1:0] w);
        int p;
`ifdef FEEDER_SIGNED_EN
        p = $signed(x) * $signed(w);
`else
        p = x * w;
`endif
        return p[DIN_W-1:0];
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_in_ready"}, op_if.in_ready, 0);
        chk({tag, "_slot_vld"}, slot_vld, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_acc_clr"}, acc_clr, 1);
    endtask

    // Entered mid cycle 0; returns mid cycle 50 (the DONE cycle) or at the abort cycle.
    task automatic frame(input logic [B_W-1:0] bias, input int uk, input int mode,
                         input bit hold, input int abort_at);
        bit fetch, vld;
        int k;
        logic [X_W-1:0] x;
        logic [W_W-1:0] w;
        start   = 1'b1;
        bias_in = bias;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = hold || (c == 10) || (c == 50);
            if (c == 20) bias_in = ~bias;
            fetch = (c <= 46) && ((c - 1) % 3 == 0);
            k     = (c - 1) / 3;
            if (fetch) begin
                case (mode)
                    0: begin x = X_W'(k + 1); w = W_W'(1); end
                    1: begin
`ifdef FEEDER_SIGNED_EN
                        x = k[0] ? 8'hFF : 8'h80;
                        w = k[0] ? 12'h001 : 12'h800;
`else
                        x = 8'hFF; w = 12'hFFF;
`endif
                    end
                    default: begin x = X_W'($urandom); w = W_W'($urandom); end
                endcase
                op_if.in_valid = (k != uk);
            end else begin
                x = X_W'($urandom);
                w = W_W'($urandom);
                op_if.in_valid = 1'($urandom_range(0, 1));
            end
            op_if.x_in = x;
            op_if.w_in = w;
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset("abort");
                sb_q.delete();
                return;
            end
            chk("in_ready", op_if.in_ready, fetch);
            if (fetch) sb_q.push_back(op_if.in_valid ? exp_prod(x, w) : '0);
            vld = (c >= 2) && (c <= 49);
            if (vld && ((c - 2) % 3 == 0)) cur_exp = sb_q.pop_front();
            chk("din", din, vld ? cur_exp : '0);
            if (c >= 2) chk("idx", idx, vld ? (c - 2) / 3 : N_TERMS - 1);
            chk("slot_vld", slot_vld, vld);
            chk("busy", busy, c <= 49);
            chk("done", done, c == 50);
            chk("acc_clr", acc_clr, c == 50);
            chk("underrun", underrun, (uk >= 0) && (c >= 2 + 3 * uk));
            chk("b", b, bias);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; bias_in = '0;
        op_if.in_valid = 1'b0; op_if.x_in = '0; op_if.w_in = '0;
        #1;
        check_reset("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_acc_clr", acc_clr, 1);
        chk("idle_busy", busy, 0);

        frame(8'd1, -1, 0, 1'b0, 0);         // nominal
        @(negedge clk); frame(8'd2, 5, 0, 1'b0, 0);      // underrun at k=5
        @(negedge clk); frame(8'h5A, -1, 1, 1'b0, 0);    // extremes
        @(negedge clk); frame(8'h33, -1, 2, 1'b1, 0);    // start held: back-to-back
        @(negedge clk); frame(8'h44, -1, 2, 1'b1, 0);
        @(negedge clk); frame(8'd1, -1, 0, 1'b0, 20);    // reset mid-frame

        start = 1'b0; op_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("held");
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        frame(8'd1, -1, 0, 1'b0, 0);

        @(negedge clk);
        start = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_acc_clr", acc_clr, 1);
        chk("end_done", done, 0);
        @(negedge clk);
        chk("end_idle", busy, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
